// File: rtl/proc_control.sv
// proc_control: multicycle T0-T3 control unit for the 16-bit processor datapath.
// Latches the instruction from DIN and decodes register/bus/ALU strobes per state.
`default_nettype none

module proc_control #(
  parameter int n = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [n-1:0] DIN,
  output logic         IRin,
  output logic [7:0]   Rin,
  output logic [7:0]   Rout,
  output logic         DINout,
  output logic         Gout,
  output logic         Ain,
  output logic         Gin,
  output logic [3:0]   ALUop,
  output logic         AddSub,
  output logic         Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [3:0] OP_MV  = 4'b0110;
  localparam logic [3:0] OP_MVI = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b0001;

  state_t       state, next_state;
  logic [n-1:0] ir;
  logic [3:0]   opcode;
  logic [2:0]   rx, ry;
  logic [7:0]   rx_sel, ry_sel;
  logic         is_alu;

  assign opcode = ir[n-1:n-4];
  assign rx     = ir[n-5:n-7];
  assign ry     = ir[n-8:n-10];
  assign rx_sel = 8'b1 << rx;
  assign ry_sel = 8'b1 << ry;
  assign is_alu = (opcode <= 4'b0101);

  generate
    if (n > 10) begin : g_ir_spare
      logic unused_ir_bits;
      assign unused_ir_bits = ^ir[n-11:0];
    end
  endgenerate

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == T0 && Run)
        ir <= DIN;
    end
  end

  always_comb begin
    next_state = state;
    IRin       = 1'b0;
    Rin        = 8'b0;
    Rout       = 8'b0;
    DINout     = 1'b0;
    Gout       = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    ALUop      = 4'b0000;
    AddSub     = 1'b0;
    Done       = 1'b0;
    case (state)
      T0: begin
        // Run is combinational here, so gate with reset to keep IRin low during reset.
        IRin       = Run & Resetn;
        next_state = Run ? T1 : T0;
      end
      T1: begin
        next_state = T0;
        if (opcode == OP_MV) begin
          Rout = ry_sel;
          Rin  = rx_sel;
          Done = 1'b1;
        end else if (opcode == OP_MVI) begin
          DINout = 1'b1;
          Rin    = rx_sel;
          Done   = 1'b1;
        end else if (is_alu) begin
          Rout       = rx_sel;
          Ain        = 1'b1;
          next_state = T2;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        Rout       = ry_sel;
        Gin        = 1'b1;
        ALUop      = opcode;
        AddSub     = (opcode == OP_SUB);
        next_state = T3;
      end
      T3: begin
        Gout       = 1'b1;
        Rin        = rx_sel;
        Done       = 1'b1;
        next_state = T0;
      end
      default: next_state = T0;
    endcase
  end

endmodule

`default_nettype wire
